multi_level_qualifier: RTL and testbench
========================================

// Module: multi_level_qualifier
// PURPOSE
//  Parametrised, multi-channel successor of the single-input cclk ready detector.
//  - Each channel synchronises an asynchronous level input (cclk, PLL lock, power-good, ...).
//  - A channel's ready output rises only after its input has been high for a programmable time.
//  - A channel drops either immediately or after a debounced low time, selected per channel.
//  - Also provides per-channel rise/fall strobes and an aggregate all-ready output for startup sequencing.
// PARAMETERS
//  NUM_CH          4         number of independent channels (>=1)
//  SYNC_STAGES     2         synchroniser flops per channel (>=2)
//  ASSERT_CYCLES   1000      consecutive high samples needed to assert ready (>=1)
//  DEASSERT_CYCLES 16        consecutive low samples needed to drop ready in debounced mode (>=1)
//  CTR_W           $clog2(max(ASSERT_CYCLES,DEASSERT_CYCLES)+1)   derived counter width; do not override
// PORTS
//  clk          in   1        system clock, single domain
//  rst          in   1        asynchronous, active-high reset
//  level_in     in   NUM_CH   asynchronous level inputs, one bit per channel
//  fast_drop    in   NUM_CH   per channel: 1 = drop ready on first low sample, 0 = debounced drop
//  ready        out  NUM_CH   qualified level per channel (registered)
//  rise_pulse   out  NUM_CH   1-cycle strobe in the cycle ready goes 0->1
//  fall_pulse   out  NUM_CH   1-cycle strobe in the cycle ready goes 1->0
//  all_ready    out  1        registered AND of ready; goes high one cycle after the last channel's ready rises
// BEHAVIOUR
//  - Reset (async assert, sync-released by the system):
//    - all synchroniser flops 0, counters 0, channel state LOW;
//    - ready, rise_pulse, fall_pulse and all_ready are all 0.
//  - Synchroniser: s[i] is level_in[i] delayed by SYNC_STAGES edges; all logic below uses s[i] only.
//  - Per-channel FSM, with states LOW, QUAL_HIGH, HIGH, QUAL_LOW:
//    - LOW:
//      - s=1: go to QUAL_HIGH, ctr=1.
//      - s=0: stay in LOW, ctr=0.
//    - QUAL_HIGH:
//      - s=0: back to LOW, ctr=0; no output change.
//      - s=1 and ctr==ASSERT_CYCLES: go to HIGH, ready<=1, rise_pulse<=1.
//      - s=1 otherwise: ctr++.
//    - HIGH:
//      - s=0 and fast_drop=1: go to LOW, ready<=0, fall_pulse<=1.
//      - s=0 and fast_drop=0: go to QUAL_LOW, ctr=1.
//    - QUAL_LOW:
//      - s=1: back to HIGH, ctr=0; ready stays 1, no pulse.
//      - s=0 and ctr==DEASSERT_CYCLES: go to LOW, ready<=0, fall_pulse<=1.
//      - fast_drop=1 in this state: drop on the next edge.
//      - otherwise: ctr++.
//    - ASSERT_CYCLES=1 case: LOW with s=1 goes straight to HIGH (ready same edge as the QUAL_HIGH entry).
//    - DEASSERT_CYCLES=1 case: behaves the same way for the drop.
//  - Latency:
//    - Assert: ready rises on edge SYNC_STAGES+ASSERT_CYCLES, counting the first edge that samples level_in=1 as edge 1.
//    - Debounced deassert: SYNC_STAGES+DEASSERT_CYCLES edges.
//    - Fast deassert: SYNC_STAGES+1 edges.
//  - Counter: saturates and never wraps; a counter that would exceed its threshold is a design error (assert in sim).
//  - Timing of outputs: ready is registered with no combinational input-to-output path; rise_pulse and fall_pulse are registered, coincident with the ready edge.
//  - Channel independence: channels are fully independent, and simultaneous events on several channels all take effect.
//  - all_ready:
//    - registered AND of the ready vector, so it lags ready by one edge;
//    - it falls one edge after any ready falls.
//  - fast_drop changes take effect on the next edge; the block does not synchronise fast_drop (quasi-static).
//  - Reset mid-operation: rst clears everything asynchronously and pulses are suppressed (no fall_pulse on reset).
// STRUCTURE
//  - Shared package (mlq_pkg):
//    - channel state encoding (LOW=2'd0, QUAL_HIGH=2'd1, HIGH=2'd2, QUAL_LOW=2'd3) as localparams;
//    - clog2/max helper functions for CTR_W.
//  - One sub-module, mlq_channel: synchroniser, counter and FSM for one channel, instantiated NUM_CH times in a generate loop.
//  - The top level holds only the all_ready register.
// TESTING
//  1. Reset check: NUM_CH=4, SYNC_STAGES=2, ASSERT=4, DEASSERT=3. Hold rst and drive level_in=4'hF -> all outputs 0. Release rst -> ready[0..3] rise on edge 6, rise_pulse=4'hF for exactly 1 cycle, all_ready=1 on edge 7.
//  2. Glitch during qualification: ch0 goes high for 3 cycles, low for 1, then high again -> ready[0] rises 6 edges after the re-rise, with no early rise_pulse.
//  3. Debounced drop: with fast_drop=0 and ready[1]=1, a 2-cycle low glitch leaves ready[1]=1 and fall_pulse=0. A 3-cycle low drops ready[1] on edge 2+3, with a single fall_pulse.
//  4. Fast drop: fast_drop[2]=1 and a 1-cycle low on ch2 -> ready[2]=0 on edge 3 with fall_pulse; all_ready falls one edge later; re-qualification takes the full 6 edges.
//  5. Simultaneous events: ch0 rises and ch3 falls on the same edge -> rise_pulse=4'b0001 and fall_pulse=4'b1000 in the same cycle.
//  6. Reset mid-operation: assert rst asynchronously while ch1 is in QUAL_HIGH with ctr=2 and ch2 is HIGH -> outputs 0 immediately, no pulses; after release, full qualification restarts.

Source files
------------

// File: rtl/mlq_pkg.sv
// Shared definitions for the multi-level qualifier.
// Holds the per-channel state encoding and the constant helper functions
// used to size the qualification counters.
package mlq_pkg;

   // Channel qualification states. The numeric values are fixed so the
   // encoding stays stable across tools and waveform viewers.
   typedef enum logic [1:0] {
      LOW       = 2'd0,
      QUAL_HIGH = 2'd1,
      HIGH      = 2'd2,
      QUAL_LOW  = 2'd3
   } chState_e;

   // Larger of two integers, used to pick the longest qualification time.
   function automatic int mlqMax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Number of bits needed to hold values 0 .. value-1.
   function automatic int mlqClog2(input int value);
      int bits;
      bits = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            bits = i + 1;
         end
      end
      return bits;
   endfunction

endpackage

// File: rtl/mlq_channel.sv
// One qualifier channel: synchroniser, qualification counter and FSM.
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   i_level      asynchronous level input
//   i_fastDrop   1 = drop ready on first low sample, 0 = debounced drop
//   o_ready      qualified level (registered)
//   o_risePulse  one-cycle strobe coincident with ready rising
//   o_fallPulse  one-cycle strobe coincident with ready falling
module mlq_channel
   import mlq_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int ASSERT_CYCLES   = 1000,
   parameter int DEASSERT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_level,
   input  logic i_fastDrop,
   output logic o_ready,
   output logic o_risePulse,
   output logic o_fallPulse
);

   localparam int CTR_W = mlqClog2(mlqMax(ASSERT_CYCLES, DEASSERT_CYCLES) + 1);

   logic [SYNC_STAGES-1:0] r_syncChain;
   chState_e               r_state;
   logic [CTR_W-1:0]       r_ctr;
   logic                   r_ready;
   logic                   r_rise;
   logic                   r_fall;

   logic                   w_sample;
   logic [CTR_W-1:0]       w_ctrInc;
   chState_e               w_nextState;
   logic [CTR_W-1:0]       w_nextCtr;
   logic                   w_nextReady;
   logic                   w_nextRise;
   logic                   w_nextFall;

   assign w_sample = r_syncChain[SYNC_STAGES-1];
   assign w_ctrInc = r_ctr + CTR_W'(1);

   // Shift the raw level through the synchroniser chain; only the last
   // stage is ever looked at by the qualification logic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_syncChain <= '0;
      end else begin
         r_syncChain <= {r_syncChain[SYNC_STAGES-2:0], i_level};
      end
   end

   // State, counter and output registers. Pulses are registered alongside
   // ready so they line up with the ready edge, and reset clears them so
   // a reset never produces a fall strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= LOW;
         r_ctr   <= '0;
         r_ready <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_ctr   <= w_nextCtr;
         r_ready <= w_nextReady;
         r_rise  <= w_nextRise;
         r_fall  <= w_nextFall;
      end
   end

   // Next-state logic. The counter holds the number of consecutive
   // qualifying samples already seen, so the threshold test uses the
   // incremented value: the sample arriving now completes the run. That
   // keeps the latency at exactly SYNC_STAGES + threshold edges and lets
   // a threshold of 1 skip the qualifying state entirely. A low sample in
   // QUAL_LOW with fast drop selected drops at once, while a high sample
   // always returns to HIGH first.
   always_comb begin
      w_nextState = r_state;
      w_nextCtr   = r_ctr;
      w_nextReady = r_ready;
      w_nextRise  = 1'b0;
      w_nextFall  = 1'b0;
      case (r_state)
         LOW: begin
            w_nextCtr = '0;
            if (w_sample) begin
               if (ASSERT_CYCLES == 1) begin
                  w_nextState = HIGH;
                  w_nextReady = 1'b1;
                  w_nextRise  = 1'b1;
               end else begin
                  w_nextState = QUAL_HIGH;
                  w_nextCtr   = CTR_W'(1);
               end
            end
         end
         QUAL_HIGH: begin
            if (!w_sample) begin
               w_nextState = LOW;
               w_nextCtr   = '0;
            end else if (w_ctrInc >= CTR_W'(ASSERT_CYCLES)) begin
               w_nextState = HIGH;
               w_nextCtr   = '0;
               w_nextReady = 1'b1;
               w_nextRise  = 1'b1;
            end else begin
               w_nextCtr = w_ctrInc;
            end
         end
         HIGH: begin
            w_nextCtr = '0;
            if (!w_sample) begin
               if (i_fastDrop || (DEASSERT_CYCLES == 1)) begin
                  w_nextState = LOW;
                  w_nextReady = 1'b0;
                  w_nextFall  = 1'b1;
               end else begin
                  w_nextState = QUAL_LOW;
                  w_nextCtr   = CTR_W'(1);
               end
            end
         end
         QUAL_LOW: begin
            if (w_sample) begin
               w_nextState = HIGH;
               w_nextCtr   = '0;
            end else if (i_fastDrop || (w_ctrInc >= CTR_W'(DEASSERT_CYCLES))) begin
               w_nextState = LOW;
               w_nextCtr   = '0;
               w_nextReady = 1'b0;
               w_nextFall  = 1'b1;
            end else begin
               w_nextCtr = w_ctrInc;
            end
         end
         default: begin
            w_nextState = LOW;
            w_nextCtr   = '0;
            w_nextReady = 1'b0;
         end
      endcase
   end

   // The counter only ever holds a partial run, so it must stay below the
   // longest threshold; reaching it would mean the saturation logic broke.
   ctrNoOverflow: assert property (@(posedge clk) disable iff (rst)
      r_ctr < CTR_W'(mlqMax(ASSERT_CYCLES, DEASSERT_CYCLES)));

   assign o_ready     = r_ready;
   assign o_risePulse = r_rise;
   assign o_fallPulse = r_fall;

endmodule

// File: rtl/multi_level_qualifier.sv
// Multi-channel level qualifier for startup sequencing.
// Each channel synchronises an asynchronous level and qualifies it with
// programmable assert/deassert times; the top adds a registered all-ready.
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   level_in    asynchronous level inputs, one per channel
//   fast_drop   per channel: 1 = immediate drop, 0 = debounced drop
//   ready       qualified level per channel
//   rise_pulse  one-cycle strobe when a channel's ready rises
//   fall_pulse  one-cycle strobe when a channel's ready falls
//   all_ready   registered AND of ready
module multi_level_qualifier
   import mlq_pkg::*;
#(
   parameter int NUM_CH          = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int ASSERT_CYCLES   = 1000,
   parameter int DEASSERT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] level_in,
   input  logic [NUM_CH-1:0] fast_drop,
   output logic [NUM_CH-1:0] ready,
   output logic [NUM_CH-1:0] rise_pulse,
   output logic [NUM_CH-1:0] fall_pulse,
   output logic              all_ready
);

   logic [NUM_CH-1:0] w_ready;
   logic              r_allReady;

   // Channels are fully independent; each gets its own copy.
   for (genvar ch = 0; ch < NUM_CH; ch++) begin : gChannel
      mlq_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .ASSERT_CYCLES   (ASSERT_CYCLES),
         .DEASSERT_CYCLES (DEASSERT_CYCLES)
      ) uChannel (
         .clk         (clk),
         .rst         (rst),
         .i_level     (level_in[ch]),
         .i_fastDrop  (fast_drop[ch]),
         .o_ready     (w_ready[ch]),
         .o_risePulse (rise_pulse[ch]),
         .o_fallPulse (fall_pulse[ch])
      );
   end

   // All-ready is taken from the registered ready vector, so it trails
   // the last rising channel by one edge and drops one edge after any
   // channel falls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_allReady <= 1'b0;
      end else begin
         r_allReady <= &w_ready;
      end
   end

   assign ready     = w_ready;
   assign all_ready = r_allReady;

endmodule

// File: tb/tb_multi_level_qualifier.sv
// Self-checking bench for multi_level_qualifier: directed scenarios with
// literal expectations plus a randomized phase, all outputs compared every
// cycle against a run-length based behavioural model.
module tb_multi_level_qualifier;

   localparam int NUM_CH = 4;
   localparam int SS     = 2;
   localparam int ACYC   = 4;
   localparam int DCYC   = 3;

   logic              clk;
   logic              rst;
   logic [NUM_CH-1:0] level_in;
   logic [NUM_CH-1:0] fast_drop;
   logic [NUM_CH-1:0] ready;
   logic [NUM_CH-1:0] rise_pulse;
   logic [NUM_CH-1:0] fall_pulse;
   logic              all_ready;

   int testCount;
   int failCount;
   logic checkEn;

   logic [NUM_CH-1:0] mPipe [SS];
   int                highRun [NUM_CH];
   int                lowRun [NUM_CH];
   logic [NUM_CH-1:0] mReady;
   logic [NUM_CH-1:0] mRise;
   logic [NUM_CH-1:0] mFall;
   logic              mAll;

   multi_level_qualifier #(
      .NUM_CH          (NUM_CH),
      .SYNC_STAGES     (SS),
      .ASSERT_CYCLES   (ACYC),
      .DEASSERT_CYCLES (DCYC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .level_in   (level_in),
      .fast_drop  (fast_drop),
      .ready      (ready),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .all_ready  (all_ready)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model: the synchronised sample is the input SS edges
   // ago; a channel becomes ready once the run of consecutive high samples
   // reaches ACYC, and drops on a low sample when either fast drop is set
   // or the run of consecutive low samples reaches DCYC.
   always @(posedge clk or posedge rst) begin
      logic [NUM_CH-1:0] s;
      logic [NUM_CH-1:0] prevReady;
      if (rst) begin
         for (int k = 0; k < SS; k++) mPipe[k] = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            highRun[i] = 0;
            lowRun[i]  = 0;
         end
         mReady = '0;
         mRise  = '0;
         mFall  = '0;
         mAll   = 1'b0;
      end else begin
         s = mPipe[SS-1];
         for (int k = SS - 1; k > 0; k--) mPipe[k] = mPipe[k-1];
         mPipe[0]  = level_in;
         prevReady = mReady;
         mAll      = &prevReady;
         for (int i = 0; i < NUM_CH; i++) begin
            if (s[i]) begin
               highRun[i] = highRun[i] + 1;
               lowRun[i]  = 0;
            end else begin
               lowRun[i]  = lowRun[i] + 1;
               highRun[i] = 0;
            end
            if (!prevReady[i] && highRun[i] >= ACYC) begin
               mReady[i] = 1'b1;
            end else if (prevReady[i] && !s[i] && (fast_drop[i] || lowRun[i] >= DCYC)) begin
               mReady[i] = 1'b0;
            end
         end
         mRise = mReady & ~prevReady;
         mFall = prevReady & ~mReady;
      end
   end

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [NUM_CH-1:0] lvl, input logic [NUM_CH-1:0] fast);
      level_in  = lvl;
      fast_drop = fast;
   endtask

   task automatic waitEdges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("cyc_ready", 8'(ready), 8'(mReady));
         checkOutput("cyc_rise", 8'(rise_pulse), 8'(mRise));
         checkOutput("cyc_fall", 8'(fall_pulse), 8'(mFall));
         checkOutput("cyc_all_ready", 8'(all_ready), 8'(mAll));
      end
   end

   // Directed scenarios followed by randomized traffic.
   initial begin
      testCount = 0;
      failCount = 0;
      checkEn   = 1'b0;
      rst       = 1'b1;
      applyStimulus(4'hF, 4'h0);
      waitEdges(3);
      checkEn = 1'b1;
      checkOutput("rst_ready", 8'(ready), 8'h0);
      checkOutput("rst_rise", 8'(rise_pulse), 8'h0);
      checkOutput("rst_all_ready", 8'(all_ready), 8'h0);

      // Reset release with every input already high.
      @(negedge clk);
      rst = 1'b0;
      waitEdges(5);
      checkOutput("s1_ready_edge5", 8'(ready), 8'h0);
      checkOutput("s1_model_edge5", 8'(mReady), 8'h0);
      waitEdges(1);
      checkOutput("s1_ready_edge6", 8'(ready), 8'hF);
      checkOutput("s1_model_edge6", 8'(mReady), 8'hF);
      checkOutput("s1_rise_edge6", 8'(rise_pulse), 8'hF);
      checkOutput("s1_all_edge6", 8'(all_ready), 8'h0);
      waitEdges(1);
      checkOutput("s1_rise_edge7", 8'(rise_pulse), 8'h0);
      checkOutput("s1_all_edge7", 8'(all_ready), 8'h1);

      // Debounced drop on ch1: a 2-sample low is absorbed, 3 samples drop.
      applyStimulus(4'b1101, 4'h0);
      waitEdges(2);
      applyStimulus(4'hF, 4'h0);
      for (int k = 0; k < 6; k++) begin
         waitEdges(1);
         checkOutput("s3_glitch_ready1", 8'(ready[1]), 8'h1);
         checkOutput("s3_glitch_fall1", 8'(fall_pulse[1]), 8'h0);
      end
      applyStimulus(4'b1101, 4'h0);
      waitEdges(3);
      applyStimulus(4'hF, 4'h0);
      waitEdges(1);
      checkOutput("s3_ready_edge4", 8'(ready), 8'hF);
      waitEdges(1);
      checkOutput("s3_ready_edge5", 8'(ready), 8'b1101);
      checkOutput("s3_fall_edge5", 8'(fall_pulse), 8'b0010);
      waitEdges(1);
      checkOutput("s3_fall_edge6", 8'(fall_pulse), 8'h0);
      waitEdges(5);
      checkOutput("s3_requal_ready", 8'(ready), 8'hF);
      checkOutput("s3_requal_all", 8'(all_ready), 8'h1);

      // Fast drop on ch2 from a single low sample.
      applyStimulus(4'hF, 4'b0100);
      waitEdges(1);
      applyStimulus(4'b1011, 4'b0100);
      waitEdges(1);
      applyStimulus(4'hF, 4'b0100);
      checkOutput("s4_ready_edge1", 8'(ready), 8'hF);
      waitEdges(1);
      checkOutput("s4_ready_edge2", 8'(ready), 8'hF);
      waitEdges(1);
      checkOutput("s4_ready_edge3", 8'(ready), 8'b1011);
      checkOutput("s4_fall_edge3", 8'(fall_pulse), 8'b0100);
      checkOutput("s4_all_edge3", 8'(all_ready), 8'h1);
      waitEdges(1);
      checkOutput("s4_all_edge4", 8'(all_ready), 8'h0);
      waitEdges(2);
      checkOutput("s4_ready_edge6", 8'(ready), 8'b1011);
      waitEdges(1);
      checkOutput("s4_ready_edge7", 8'(ready), 8'hF);
      checkOutput("s4_rise_edge7", 8'(rise_pulse), 8'b0100);
      applyStimulus(4'hF, 4'h0);
      waitEdges(2);

      // Glitch during qualification on ch0.
      applyStimulus(4'b1110, 4'h0);
      waitEdges(8);
      checkOutput("s2_ch0_low", 8'(ready), 8'b1110);
      applyStimulus(4'hF, 4'h0);
      waitEdges(3);
      applyStimulus(4'b1110, 4'h0);
      waitEdges(1);
      applyStimulus(4'hF, 4'h0);
      for (int k = 5; k <= 9; k++) begin
         waitEdges(1);
         checkOutput("s2_no_early_ready0", 8'(ready[0]), 8'h0);
         checkOutput("s2_no_early_rise0", 8'(rise_pulse[0]), 8'h0);
      end
      waitEdges(1);
      checkOutput("s2_ready_edge10", 8'(ready), 8'hF);
      checkOutput("s2_rise_edge10", 8'(rise_pulse), 8'b0001);

      // Simultaneous rise on ch0 and fast fall on ch3.
      applyStimulus(4'b1110, 4'b1000);
      waitEdges(8);
      applyStimulus(4'hF, 4'b1000);
      waitEdges(3);
      applyStimulus(4'b0111, 4'b1000);
      waitEdges(3);
      checkOutput("s5_rise", 8'(rise_pulse), 8'b0001);
      checkOutput("s5_fall", 8'(fall_pulse), 8'b1000);
      checkOutput("s5_ready", 8'(ready), 8'b0111);

      // Reset while ch1 is qualifying and ch2 is high.
      applyStimulus(4'b0101, 4'b0010);
      waitEdges(6);
      applyStimulus(4'b0111, 4'b0010);
      waitEdges(4);
      checkOutput("s6_pre_rst_ready", 8'(ready), 8'b0101);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("s6_rst_ready", 8'(ready), 8'h0);
      checkOutput("s6_rst_rise", 8'(rise_pulse), 8'h0);
      checkOutput("s6_rst_fall", 8'(fall_pulse), 8'h0);
      checkOutput("s6_rst_all", 8'(all_ready), 8'h0);
      applyStimulus(4'hF, 4'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      waitEdges(5);
      checkOutput("s6_requal_edge5", 8'(ready), 8'h0);
      waitEdges(1);
      checkOutput("s6_requal_edge6", 8'(ready), 8'hF);
      checkOutput("s6_requal_rise", 8'(rise_pulse), 8'hF);

      // Randomized traffic: levels toggle with ~1/8 probability per cycle so
      // both full qualifications and short glitches occur.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         logic [NUM_CH-1:0] lvl;
         logic [NUM_CH-1:0] fast;
         @(negedge clk);
         lvl  = level_in;
         fast = fast_drop;
         for (int i = 0; i < NUM_CH; i++) begin
            if ($urandom_range(0, 7) == 0) lvl[i] = ~lvl[i];
            if ($urandom_range(0, 63) == 0) fast[i] = ~fast[i];
         end
         applyStimulus(lvl, fast);
         if ($urandom_range(0, 599) == 0) begin
            #2;
            rst = 1'b1;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
         end
      end

      waitEdges(2);
      checkEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
